// File: rtl/mux_response_checker.sv
// Self-checking sweep engine for a 3-input / 1-output combinational unit (2:1 mux).
// Drives all eight {x1,s,x2} vectors, samples f after a hold time and tallies mismatches.
module mux_response_checker #(
  parameter int unsigned HOLD_CYCLES = 100,   // legal range 1..255
  parameter logic [7:0]  EXPECTED    = 8'hB8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       f_i,
  output logic       x1_o,
  output logic       s_o,
  output logic       x2_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [3:0] err_count_o,
  output logic [2:0] first_fail_o,
  output logic [2:0] vec_idx_o
);

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e     state_q,      state_d;
  logic [2:0] vec_idx_q,    vec_idx_d;
  logic [3:0] err_count_q,  err_count_d;
  logic [2:0] first_fail_q, first_fail_d;
  logic [7:0] hold_q,       hold_d;
  logic       mismatch;

  assign mismatch = (f_i != EXPECTED[vec_idx_q]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      vec_idx_q    <= 3'd0;
      err_count_q  <= 4'd0;
      first_fail_q <= 3'd0;
      hold_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      hold_q       <= hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    hold_d       = hold_q;

    unique case (state_q)
      IDLE, DONE: begin
        // A new sweep always starts with cleared results; start while busy is simply not looked at.
        if (start_i) begin
          state_d      = DRIVE;
          vec_idx_d    = 3'd0;
          err_count_d  = 4'd0;
          first_fail_d = 3'd0;
          hold_d       = HOLD_RELOAD;
        end
      end
      DRIVE: begin
        if (hold_q == 8'd0) begin
          state_d = SAMPLE;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          err_count_d = err_count_q + 4'd1;
          if (err_count_q == 4'd0) begin
            first_fail_d = vec_idx_q;
          end
        end
        if (vec_idx_q == 3'd7) begin
          state_d = DONE;
        end else begin
          vec_idx_d = vec_idx_q + 3'd1;
          hold_d    = HOLD_RELOAD;
          state_d   = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // UUT inputs come straight from the vector register so they never glitch.
  assign x1_o         = vec_idx_q[2];
  assign s_o          = vec_idx_q[1];
  assign x2_o         = vec_idx_q[0];
  assign vec_idx_o    = vec_idx_q;
  assign err_count_o  = err_count_q;
  assign first_fail_o = first_fail_q;
  assign busy_o       = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done_o       = (state_q == DONE);
  assign pass_o       = (state_q == DONE) && (err_count_q == 4'd0);

endmodule

// File: tb/tb_mux_response_checker.sv
// Directed bench: two checker instances (hold 4 and hold 1) driving an emulated mux with
// selectable faults; sweeps come from a vector table, reset/busy corners are hand sequences.
module tb_mux_response_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0, start1 = 1'b0;
  logic f4, f1;
  logic x1_4, s_4, x2_4, busy4, done4, pass4;
  logic x1_1, s_1, x2_1, busy1, done1, pass1;
  logic [3:0] err4, err1;
  logic [2:0] ff4, ff1, vec4, vec1;

  int fMode = 0;
  int sel = 0;
  int checks = 0;
  int failures = 0;

  logic curDone, curBusy, curPass;
  logic [2:0] curX, curVec, curFirst;
  logic [3:0] curErr;

  always #5 clk = ~clk;

  mux_response_checker #(.HOLD_CYCLES(4), .EXPECTED(8'hB8)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .f_i(f4),
    .x1_o(x1_4), .s_o(s_4), .x2_o(x2_4), .busy_o(busy4), .done_o(done4), .pass_o(pass4),
    .err_count_o(err4), .first_fail_o(ff4), .vec_idx_o(vec4)
  );

  mux_response_checker #(.HOLD_CYCLES(1), .EXPECTED(8'hB8)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .f_i(f1),
    .x1_o(x1_1), .s_o(s_1), .x2_o(x2_1), .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_count_o(err1), .first_fail_o(ff1), .vec_idx_o(vec1)
  );

  // Emulated UUT: 0 good mux, 1 stuck-0, 2 inverted, 3 f=x1, 4 stuck-1.
  function automatic logic fModel(input int mode, input logic x1, input logic s, input logic x2);
    logic good;
    good = s ? x2 : x1;
    case (mode)
      0:       return good;
      1:       return 1'b0;
      2:       return ~good;
      3:       return x1;
      default: return 1'b1;
    endcase
  endfunction

  always_comb f4 = fModel(fMode, x1_4, s_4, x2_4);
  always_comb f1 = fModel(fMode, x1_1, s_1, x2_1);

  always_comb begin
    curDone  = (sel == 1) ? done1 : done4;
    curBusy  = (sel == 1) ? busy1 : busy4;
    curPass  = (sel == 1) ? pass1 : pass4;
    curX     = (sel == 1) ? {x1_1, s_1, x2_1} : {x1_4, s_4, x2_4};
    curVec   = (sel == 1) ? vec1 : vec4;
    curFirst = (sel == 1) ? ff1 : ff4;
    curErr   = (sel == 1) ? err1 : err4;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setStart(input int which, input logic v);
    if (which == 1) start1 = v;
    else            start4 = v;
  endtask

  // One full sweep; optionally pokes start mid-sweep, which must not disturb anything.
  task automatic applyStimulus(input int which, input int mode, input bit poke,
                               input int expErr, input int expFirst, input bit expPass,
                               input string name);
    int h, total, cyc, expV;
    bit traceBad;
    h = (which == 1) ? 1 : 4;
    total = 8 * (h + 1);
    sel = which;
    fMode = mode;
    @(negedge clk);
    setStart(which, 1'b1);
    @(posedge clk);
    #1;
    setStart(which, 1'b0);
    cyc = 0;
    traceBad = 1'b0;
    while (!curDone && cyc < total + 20) begin
      expV = cyc / (h + 1);
      if (int'(curVec) != expV || int'(curX) != expV || !curBusy) traceBad = 1'b1;
      if (poke && cyc == 7) setStart(which, 1'b1);
      if (poke && cyc == 8) setStart(which, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
    end
    setStart(which, 1'b0);
    checkOutput({name, " latency"}, cyc, total);
    checkOutput({name, " vector trace"}, int'(traceBad), 0);
    checkOutput({name, " done"}, int'(curDone), 1);
    checkOutput({name, " pass"}, int'(curPass), int'(expPass));
    checkOutput({name, " err_count"}, int'(curErr), expErr);
    checkOutput({name, " first_fail"}, int'(curFirst), expFirst);
    checkOutput({name, " busy"}, int'(curBusy), 0);
    checkOutput({name, " vec_idx"}, int'(curVec), 7);
  endtask

  typedef struct {
    int    mode;
    bit    poke;
    int    expErr;
    int    expFirst;
    bit    expPass;
    string name;
  } vec_t;

  vec_t table_v[6];

  initial begin
    int wait4;
    table_v[0] = '{0, 1'b0, 0, 0, 1'b1, "good"};
    table_v[1] = '{1, 1'b0, 4, 3, 1'b0, "stuck0"};
    table_v[2] = '{2, 1'b0, 8, 0, 1'b0, "inverted"};
    table_v[3] = '{0, 1'b1, 0, 0, 1'b1, "good_rerun_poke"};
    table_v[4] = '{3, 1'b0, 2, 3, 1'b0, "f_eq_x1"};
    table_v[5] = '{4, 1'b0, 4, 0, 1'b0, "stuck1"};

    #23;
    checkOutput("reset dut4 outputs", int'({x1_4, s_4, x2_4, busy4, done4, pass4, err4, ff4, vec4}), 0);
    checkOutput("reset dut1 outputs", int'({x1_1, s_1, x2_1, busy1, done1, pass1, err1, ff1, vec1}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle without start", int'({busy4, done4}), 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, table_v[i].mode, table_v[i].poke, table_v[i].expErr,
                    table_v[i].expFirst, table_v[i].expPass, table_v[i].name);
    end

    applyStimulus(1, 0, 1'b0, 0, 0, 1'b1, "hold1_good");

    // Reset in the middle of vector 5 with errors already counted.
    sel = 0;
    fMode = 1;
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    wait4 = 0;
    while (vec4 != 3'd5 && wait4 < 100) begin
      @(posedge clk);
      #1;
      wait4++;
    end
    checkOutput("reach vector 5", int'(vec4), 5);
    @(posedge clk);
    #1;
    checkOutput("pre-reset err_count", int'(err4), 2);
    checkOutput("pre-reset busy", int'(busy4), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset outputs", int'({x1_4, s_4, x2_4, busy4, done4, err4, vec4}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post-reset stays idle", int'({busy4, done4, vec4, err4}), 0);

    applyStimulus(0, 0, 1'b0, 0, 0, 1'b1, "after_reset_good");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
